// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, captures imem words into a one-entry
// valid/ready output register, stops on HALT_WORD. Optional FETCH_PERF_EN adds a delivered-instruction counter.
module fetch_sequencer #(
   parameter int unsigned          ADDR_W    = 8,
   parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
   parameter logic [31:0]          HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              resume,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic              halted_q, halted_d;

   logic handshake;
   logic slot_free;
   logic is_halt_word;

   assign handshake    = out_valid_q & out_ready;
   assign slot_free    = ~out_valid_q | out_ready;
   assign is_halt_word = (imem_data == HALT_WORD);

   // Next-state and output-register logic; redirect overrides everything else.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;

      unique case (state_q)
         ST_RUN: begin
            if (is_halt_word) begin
               // Empty after this cycle means straight to HALT; otherwise wait for the drain.
               if (slot_free) begin
                  out_valid_d = 1'b0;
                  state_d     = ST_HALT;
               end else begin
                  state_d     = ST_DRAIN;
               end
            end else if (slot_free) begin
               out_instr_d = imem_data;
               out_pc_d    = pc_q;
               out_valid_d = 1'b1;
               pc_d        = pc_q + ADDR_W'(1);
            end
         end
         ST_DRAIN: begin
            if (handshake) begin
               out_valid_d = 1'b0;
               state_d     = ST_HALT;
            end
         end
         ST_HALT: begin
            out_valid_d = 1'b0;
            if (resume) begin
               pc_d    = pc_q + ADDR_W'(1);
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d     = ST_RUN;
            out_valid_d = 1'b0;
         end
      endcase

      if (redirect_valid) begin
         pc_d        = redirect_pc;
         out_valid_d = 1'b0;
         state_d     = ST_RUN;
      end

      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0;
         out_pc_q    <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         halted_q    <= halted_d;
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_pc    = out_pc_q;
   assign halted    = halted_q;

`ifdef FETCH_PERF_EN
   logic [15:0] fetch_count_q, fetch_count_d;

   // Saturating count of delivered instructions, including one accepted during a redirect.
   always_comb begin
      fetch_count_d = fetch_count_q;
      if (handshake && (fetch_count_q != 16'hFFFF)) begin
         fetch_count_d = fetch_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_q <= 16'h0;
      end else begin
         fetch_count_q <= fetch_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
`else
   assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed sequences push expected (instr, pc)
// pairs; a negedge monitor pops and compares on every out_valid & out_ready handshake.
module tb_fetch_sequencer;

   localparam int unsigned ADDR_W = 8;
   localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              resume;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              halted;
   logic [15:0]       fetch_count;

   logic [31:0] mem [256];
   logic [39:0] exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_pushed = 0;

   fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(8'h00), .HALT_WORD(HALT)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .resume(resume),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [ADDR_W-1:0] pc);
      exp_q.push_back({mem[pc], pc});
      n_pushed++;
   endtask

   task automatic push_range(input int first, input int last);
      for (int a = first; a <= last; a++) push(ADDR_W'(a));
   endtask

   task automatic wait_halted(input string name);
      int k;
      k = 0;
      while (!halted && k < 40) begin
         step();
         k++;
      end
      check({name, "_halted"}, 32'(halted), 32'd1);
   endtask

   task automatic check_count(input string name);
`ifdef FETCH_PERF_EN
      check(name, 32'(fetch_count), 32'(n_pushed));
`else
      check(name, 32'(fetch_count), 32'd0);
`endif
   endtask

   // Monitor: every handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got instr %h pc %h expected none", out_instr, out_pc);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            if ({out_instr, out_pc} !== e) begin
               n_fail++;
               $display("FAIL sb_data: got instr %h pc %h expected instr %h pc %h",
                        out_instr, out_pc, e[39:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'h5A, 16'h0000, 8'(i)};
      mem[0]    = 32'h3e80_0293;
      mem[1]    = 32'h0051_2023;
      mem[2]    = HALT;
      mem[8'h08] = HALT;
      mem[8'h18] = HALT;
      mem[8'h22] = HALT;
      mem[8'h38] = HALT;

      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; resume = 1'b0; out_ready = 1'b0;
      step(); step();
      check("rst_valid",  32'(out_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_addr",   32'(imem_addr), 32'd0);
      check("rst_instr",  out_instr, 32'd0);
      check("rst_count",  32'(fetch_count), 32'd0);

      // 1: basic stream into halt word
      push_range(0, 1);
      reset = 1'b0; out_ready = 1'b1;
      step();
      check("t1_first_valid", 32'(out_valid), 32'd1);
      wait_halted("t1");
      check("t1_addr", 32'(imem_addr), 32'd2);
      check_count("t1_count");

      // 5a: resume from halt at 2
      push_range(3, 7);
      resume = 1'b1; step(); resume = 1'b0; step();
      check("t5a_valid", 32'(out_valid), 32'd1);
      check("t5a_pc", 32'(out_pc), 32'd3);
      wait_halted("t5a");
      check("t5a_addr", 32'(imem_addr), 32'd8);

      // 2: stall with ready low for three cycles
      out_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 8'h30; step(); redirect_valid = 1'b0; step();
      check("t2_pc", 32'(out_pc), 32'h30);
      for (int c = 0; c < 3; c++) begin
         step();
         check("t2_hold_pc", 32'(out_pc), 32'h30);
         check("t2_hold_instr", out_instr, mem[8'h30]);
         check("t2_hold_addr", 32'(imem_addr), 32'h31);
      end
      push_range(8'h30, 8'h37);
      out_ready = 1'b1;
      wait_halted("t2");
      check("t2_addr", 32'(imem_addr), 32'h38);

      // 3: redirect flushes an entry held by ready low
      out_ready = 1'b0;
      resume = 1'b1; step(); resume = 1'b0; step();
      check("t3_stuck_pc", 32'(out_pc), 32'h39);
      redirect_valid = 1'b1; redirect_pc = 8'h10; step(); redirect_valid = 1'b0;
      check("t3_flush_valid", 32'(out_valid), 32'd0);
      check("t3_flush_addr", 32'(imem_addr), 32'h10);
      step();
      check("t3_new_valid", 32'(out_valid), 32'd1);
      check("t3_new_pc", 32'(out_pc), 32'h10);
      push_range(8'h10, 8'h17);
      out_ready = 1'b1;
      wait_halted("t3");

      // 4: redirect to top of address space wraps
      push(8'hFF); push(8'h00); push(8'h01);
      redirect_valid = 1'b1; redirect_pc = 8'hFF; step(); redirect_valid = 1'b0;
      wait_halted("t4");
      check("t4_addr", 32'(imem_addr), 32'd2);
      check_count("t4_count");

      // 5b: resume and redirect together, redirect wins
      push_range(8'h20, 8'h21);
      resume = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h20; step();
      resume = 1'b0; redirect_valid = 1'b0; step();
      check("t5b_pc", 32'(out_pc), 32'h20);
      wait_halted("t5b");
      check("t5b_addr", 32'(imem_addr), 32'h22);

      // 7: redirect in the same cycle as a handshake still delivers the entry
      push(8'h40);
      redirect_valid = 1'b1; redirect_pc = 8'h40; step(); redirect_valid = 1'b0; step();
      check("t7_pc", 32'(out_pc), 32'h40);
      push_range(8'h20, 8'h21);
      redirect_valid = 1'b1; redirect_pc = 8'h20; step(); redirect_valid = 1'b0;
      check("t7_flush_valid", 32'(out_valid), 32'd0);
      wait_halted("t7");
      check_count("t7_count");

      // 6: reset in the middle of RUN with a valid entry
      out_ready = 1'b0;
      resume = 1'b1; step(); resume = 1'b0; step();
      check("t6_pre_valid", 32'(out_valid), 32'd1);
      reset = 1'b1; step();
      check("t6_valid", 32'(out_valid), 32'd0);
      check("t6_halted", 32'(halted), 32'd0);
      check("t6_addr", 32'(imem_addr), 32'd0);
      check("t6_count", 32'(fetch_count), 32'd0);
      reset = 1'b0; step();
      check("t6_restart_pc", 32'(out_pc), 32'd0);

      step();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
